// File: rtl/toy_bpu_update_ctrl.sv
// Branch predictor update controller.
// The commit stream looks up the predictor table in S0. In S1 the returned
// entry is trained, or a new entry is allocated, and written back. Cancelled
// commits produce a registered redirect in S2.
module toy_bpu_update_ctrl #(
    parameter int PC_WIDTH       = 32,
    parameter int PRED_BLOCK_LEN = 8,
    parameter int TBL_DEPTH      = 256,
    parameter int TAG_W          = 8,
    localparam int IDX_W         = $clog2(TBL_DEPTH),
    localparam int OFF_W         = $clog2(PRED_BLOCK_LEN),
    localparam int ENT_W         = 1 + TAG_W + 2 + OFF_W + PC_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fe_commit_vld,
    input  logic [PC_WIDTH-1:0] fe_commit_pc,
    input  logic                fe_commit_taken,
    input  logic                fe_commit_taken_err,
    input  logic [OFF_W-1:0]    fe_commit_offset,
    input  logic [PC_WIDTH-1:0] fe_commit_tgt_pc,
    input  logic [PC_WIDTH-1:0] fe_commit_pred_pc,
    input  logic                fe_cancel_vld,
    input  logic                fe_cancel_pend,
    output logic                tbl_rd_en,
    output logic [IDX_W-1:0]    tbl_rd_idx,
    input  logic [ENT_W-1:0]    tbl_rd_data,
    output logic                tbl_wr_en,
    output logic [IDX_W-1:0]    tbl_wr_idx,
    output logic [ENT_W-1:0]    tbl_wr_data,
    output logic                redirect_vld,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [15:0]         mispred_cnt
);

    // Byte size of one prediction block (instructions are 4 bytes).
    localparam logic [PC_WIDTH-1:0] BLK_BYTES = PC_WIDTH'(PRED_BLOCK_LEN * 4);
    // Entry field positions within {valid, tag, ctr, offset, tgt}.
    localparam int TGT_LSB = 0;
    localparam int OFF_LSB = PC_WIDTH;
    localparam int CTR_LSB = PC_WIDTH + OFF_W;
    localparam int TAG_LSB = PC_WIDTH + OFF_W + 2;
    localparam int VLD_BIT = ENT_W - 1;

    // S0 address decode
    logic [IDX_W-1:0] s0_idx;
    logic [TAG_W-1:0] s0_tag;
    logic             pc_unused;

    // S1 pipeline registers
    logic                s1_vld_reg;
    logic [IDX_W-1:0]    s1_idx_reg;
    logic [TAG_W-1:0]    s1_tag_reg;
    logic                s1_taken_reg;
    logic                s1_taken_err_reg;
    logic [OFF_W-1:0]    s1_offset_reg;
    logic [PC_WIDTH-1:0] s1_tgt_pc_reg;
    logic [PC_WIDTH-1:0] s1_pred_pc_reg;
    logic                s1_cancel_vld_reg;
    logic                s1_cancel_pend_reg;

    // Write-to-read bypass: the entry written in the previous cycle
    logic                byp_vld_reg;
    logic [IDX_W-1:0]    byp_idx_reg;
    logic [ENT_W-1:0]    byp_data_reg;

    // S1 compute
    logic                s1_live;
    logic [ENT_W-1:0]    eff_data;
    logic [TAG_W-1:0]    eff_tag;
    logic [1:0]          eff_ctr;
    logic                hit;
    logic                wr_en_next;
    logic [1:0]          ctr_next;
    logic [ENT_W-1:0]    wr_data_next;

    // S2 registers
    logic                redirect_vld_reg;
    logic [PC_WIDTH-1:0] redirect_pc_reg;
    logic [15:0]         mispred_cnt_reg;

    assign s0_idx     = fe_commit_pc[2+OFF_W +: IDX_W];
    assign s0_tag     = fe_commit_pc[2+OFF_W+IDX_W +: TAG_W];
    // Byte-offset and upper PC bits do not take part in indexing or tagging.
    assign pc_unused  = ^fe_commit_pc;

    assign tbl_rd_en  = fe_commit_vld;
    assign tbl_rd_idx = s0_idx;

    // Capture the S0 commit fields into S1; payload only loads on a valid commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg         <= 1'b0;
            s1_idx_reg         <= '0;
            s1_tag_reg         <= '0;
            s1_taken_reg       <= 1'b0;
            s1_taken_err_reg   <= 1'b0;
            s1_offset_reg      <= '0;
            s1_tgt_pc_reg      <= '0;
            s1_pred_pc_reg     <= '0;
            s1_cancel_vld_reg  <= 1'b0;
            s1_cancel_pend_reg <= 1'b0;
        end else begin
            s1_vld_reg <= fe_commit_vld;
            if (fe_commit_vld) begin
                s1_idx_reg         <= s0_idx;
                s1_tag_reg         <= s0_tag;
                s1_taken_reg       <= fe_commit_taken;
                s1_taken_err_reg   <= fe_commit_taken_err;
                s1_offset_reg      <= fe_commit_offset;
                s1_tgt_pc_reg      <= fe_commit_tgt_pc;
                s1_pred_pc_reg     <= fe_commit_pred_pc;
                s1_cancel_vld_reg  <= fe_cancel_vld;
                s1_cancel_pend_reg <= fe_cancel_pend;
            end
        end
    end

    // The RAM returns pre-write data when read and written to the same index
    // in one cycle, so the last written entry overrides it on an index match.
    assign eff_data = (byp_vld_reg && (byp_idx_reg == s1_idx_reg)) ? byp_data_reg : tbl_rd_data;
    assign eff_tag  = eff_data[TAG_LSB +: TAG_W];
    assign eff_ctr  = eff_data[CTR_LSB +: 2];
    assign hit      = eff_data[VLD_BIT] && (eff_tag == s1_tag_reg);
    // A pending-cancel entry only performs its lookup; it has no side effects.
    assign s1_live  = s1_vld_reg && !s1_cancel_pend_reg;

    // Train or allocate the entry: taken strengthens/allocates, not-taken weakens on hit.
    always_comb begin
        wr_en_next   = 1'b0;
        ctr_next     = eff_ctr;
        wr_data_next = eff_data;
        if (s1_live) begin
            if (s1_taken_reg) begin
                wr_en_next = 1'b1;
                if (!hit) begin
                    ctr_next = 2'b10;
                end else if (eff_ctr != 2'b11) begin
                    ctr_next = eff_ctr + 2'b01;
                end
                wr_data_next = {1'b1, s1_tag_reg, ctr_next, s1_offset_reg, s1_tgt_pc_reg};
            end else if (hit) begin
                wr_en_next = 1'b1;
                if (eff_ctr != 2'b00) begin
                    ctr_next = eff_ctr - 2'b01;
                end
                wr_data_next = {eff_data[VLD_BIT -: 1+TAG_W], ctr_next,
                                eff_data[OFF_LSB +: OFF_W], eff_data[TGT_LSB +: PC_WIDTH]};
            end
        end
    end

    assign tbl_wr_en   = wr_en_next;
    assign tbl_wr_idx  = s1_idx_reg;
    assign tbl_wr_data = wr_data_next;

    // Remember this cycle's write so the next S1 entry can see it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_vld_reg  <= 1'b0;
            byp_idx_reg  <= '0;
            byp_data_reg <= '0;
        end else begin
            byp_vld_reg <= wr_en_next;
            if (wr_en_next) begin
                byp_idx_reg  <= s1_idx_reg;
                byp_data_reg <= wr_data_next;
            end
        end
    end

    // S2: registered redirect pulse and saturating mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_vld_reg <= 1'b0;
            redirect_pc_reg  <= '0;
            mispred_cnt_reg  <= '0;
        end else begin
            redirect_vld_reg <= s1_live && s1_cancel_vld_reg;
            if (s1_live && s1_cancel_vld_reg) begin
                redirect_pc_reg <= s1_taken_reg ? s1_tgt_pc_reg : (s1_pred_pc_reg + BLK_BYTES);
            end
            if (s1_live && s1_taken_err_reg && (mispred_cnt_reg != 16'hFFFF)) begin
                mispred_cnt_reg <= mispred_cnt_reg + 16'd1;
            end
        end
    end

    assign redirect_vld = redirect_vld_reg;
    assign redirect_pc  = redirect_pc_reg;
    assign mispred_cnt  = mispred_cnt_reg;

endmodule

// File: doc/toy_bpu_update_ctrl.md
TOY_BPU_UPDATE_CTRL -- requirements
Module: toy_bpu_update_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, meaning PC width.
REQ-002 SHALL have parameter PRED_BLOCK_LEN, default 8, meaning instructions per prediction block (power of 2).
REQ-003 SHALL have parameter TBL_DEPTH, default 256, meaning predictor table entries (power of 2); IDX_W=$clog2(TBL_DEPTH).
REQ-004 SHALL have parameter TAG_W, default 8, meaning tag width; OFF_W=$clog2(PRED_BLOCK_LEN).
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fe_commit_vld  input  1  commit entry valid; no backpressure, every valid cycle is consumed.
REQ-008 fe_commit_pc  input  PC_WIDTH  block PC.
REQ-009 fe_commit_taken / fe_commit_taken_err  input  1 each  resolved taken / mispredicted.
REQ-010 fe_commit_offset  input  OFF_W  taken instruction offset in block.
REQ-011 fe_commit_tgt_pc / fe_commit_pred_pc  input  PC_WIDTH each  resolved target / block pred PC.
REQ-012 fe_cancel_vld / fe_cancel_pend  input  1 each  entry carries cancel / pending-cancel.
REQ-013 tbl_rd_en / tbl_rd_idx  output  1 / IDX_W  table read request; data returns next cycle.
REQ-014 tbl_rd_data  input  1+TAG_W+2+OFF_W+PC_WIDTH  {valid,tag,ctr,offset,tgt}.
REQ-015 tbl_wr_en / tbl_wr_idx / tbl_wr_data  output  1 / IDX_W / same as rd_data  table write.
REQ-016 redirect_vld / redirect_pc  output  1 / PC_WIDTH  frontend redirect pulse.
REQ-017 mispred_cnt  output  16  saturating mispredict count.

Function
REQ-018 SHALL be a 3-stage pipeline: S0 (input cycle, read issue), S1 (rdata return, compute, write), S2 (registered redirect).
REQ-019 idx=pc[2+OFF_W +: IDX_W]; tag=pc[2+OFF_W+IDX_W +: TAG_W].
REQ-020 S0: tbl_rd_en=fe_commit_vld (combinational), tbl_rd_idx=idx; S0 fields SHALL be registered into S1 with s1_vld.
REQ-021 hit=valid && tag match on S1 effective data (REQ-025).
REQ-022 taken && hit: write ctr=sat_inc(ctr) (max 2'b11), offset, tgt=tgt_pc; taken && miss: allocate {1,tag,2'b10,offset,tgt_pc}.
REQ-023 not taken && hit: write ctr=sat_dec(ctr) (min 2'b00), other fields kept; not taken && miss: no write.
REQ-024 fe_cancel_pend=1 entry SHALL issue read but SHALL NOT write table, redirect, or count.
REQ-025 Bypass: if S1 idx equals idx written in the immediately preceding cycle, S1 SHALL use that written data instead of tbl_rd_data; back-to-back same-index updates SHALL compose exactly.
REQ-026 tbl_wr_en SHALL be asserted in the S1 cycle (1 cycle after input), at most one write per cycle.
REQ-027 S1 with cancel_vld && !cancel_pend: redirect_vld=1 in the following cycle (2 cycles after input) for exactly 1 cycle; redirect_pc=taken ? tgt_pc : pred_pc + (PRED_BLOCK_LEN<<2), modulo 2^PC_WIDTH.
REQ-028 mispred_cnt SHALL +1 per S1 entry with taken_err && !cancel_pend, saturating at 16'hFFFF.
REQ-029 Back-to-back valid inputs every cycle SHALL sustain throughput 1/cycle with no drop.
REQ-030 Inputs with fe_commit_vld=0 SHALL be ignored (payload don't-care).

Reset
REQ-031 Async rst_n low: s1_vld, bypass valid, redirect_vld, tbl_wr_en, mispred_cnt SHALL clear to 0; redirect_pc 0; tbl_rd_en follows input (0 if vld 0).
REQ-032 Reset mid-operation SHALL discard in-flight S1/S2 entries with no write or redirect after deassertion.
REQ-033 Table contents are not reset by this block.

Verification
REQ-034 Taken commit pc=0x1000, table entry invalid -> rd_idx=0x80 at t, wr {1,tag 0x00,2'b10,off,tgt} at t+1.
REQ-035 Two consecutive taken commits same pc, entry ctr=2'b10 -> writes ctr 2'b11 then 2'b11 (bypass used, saturate).
REQ-036 Not-taken on hit ctr=2'b00 -> write ctr 2'b00; not-taken miss -> tbl_wr_en stays 0.
REQ-037 cancel_vld=1, taken=0, pred_pc=0x2000 -> redirect_vld pulse at t+2, redirect_pc=0x2020.
REQ-038 cancel_vld=1, cancel_pend=1, taken_err=1 -> no write, no redirect, mispred_cnt unchanged.
REQ-039 rst_n asserted the cycle after a cancel input -> no redirect_vld after release; mispred_cnt=0.
